// File: rtl/lif_neuron_pipe.sv
// Two-stage leaky integrate-and-fire update engine between the neuron SRAM read and write ports.
// Stage 1 registers the operation; stage 2 holds the result and feeds it back for same-address follow-ups.
module lif_neuron_pipe #(
  parameter int MEM_W      = 12,
  parameter int WGT_W      = 8,
  parameter int WGT_SHIFT  = 1,
  parameter int CNT_W      = 7,
  parameter int ADDR_W     = 8,
  parameter int LEAK_EN    = 0,
  parameter int RESET_MODE = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [MEM_W-1:0]  in_state,
  input  logic [CNT_W-1:0]  in_cnt,
  input  logic [WGT_W-1:0]  in_weight,
  input  logic [MEM_W-1:0]  param_thr,
  input  logic [MEM_W-1:0]  param_leak,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [MEM_W-1:0]  out_state,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_spike
);

  localparam logic [1:0] OP_SYN  = 2'b00;
  localparam logic [1:0] OP_STEP = 2'b01;
  localparam logic [1:0] OP_REF  = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;
  localparam logic [MEM_W-1:0] MAX_POS = {1'b0, {(MEM_W-1){1'b1}}};
  localparam logic [MEM_W-1:0] MAX_NEG = {1'b1, {(MEM_W-1){1'b0}}};

  function automatic logic [MEM_W-1:0] f_sat(input logic [MEM_W:0] v);
    logic [MEM_W-1:0] res;
    if (v[MEM_W] == v[MEM_W-1]) res = v[MEM_W-1:0];
    else if (v[MEM_W])          res = MAX_NEG;
    else                        res = MAX_POS;
    return res;
  endfunction

  logic              r1_valid;
  logic [1:0]        r1_op;
  logic [ADDR_W-1:0] r1_addr;
  logic [MEM_W-1:0]  r1_state;
  logic [CNT_W-1:0]  r1_cnt;
  logic [WGT_W-1:0]  r1_weight;
  logic [MEM_W-1:0]  r1_thr;
  logic [MEM_W-1:0]  r1_leak;

  logic              r2_valid;
  logic [ADDR_W-1:0] r2_addr;
  logic [MEM_W-1:0]  r2_state;
  logic [CNT_W-1:0]  r2_cnt;
  logic              r2_spike;

  logic              w_adv;
  logic              w_fwd;
  logic [MEM_W-1:0]  w_st;
  logic [CNT_W-1:0]  w_cnt;
  logic [MEM_W-1:0]  w_wext;
  logic [MEM_W:0]    w_syn;
  logic [MEM_W:0]    w_st_x;
  logic [MEM_W:0]    w_lk_x;
  logic [MEM_W:0]    w_dec;
  logic [MEM_W:0]    w_inc;
  logic [MEM_W-1:0]  w_leaked;
  logic              w_spike;
  logic [MEM_W:0]    w_sub;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [MEM_W-1:0]  w_nstate;
  logic [CNT_W-1:0]  w_ncnt;
  logic              w_nspike;

  assign w_adv    = !r2_valid || out_ready;
  assign in_ready = w_adv;

  // The result still sitting in stage 2 has not reached the SRAM yet, so it overrides the stale read.
  assign w_fwd = r2_valid && (r2_addr == r1_addr);
  assign w_st  = w_fwd ? r2_state : r1_state;
  assign w_cnt = w_fwd ? r2_cnt   : r1_cnt;

  assign w_wext = {{(MEM_W-WGT_W){r1_weight[WGT_W-1]}}, r1_weight} << WGT_SHIFT;
  assign w_syn  = {w_st[MEM_W-1], w_st} + {w_wext[MEM_W-1], w_wext};

  // One guard bit covers state +/- an unsigned leak of up to full MEM_W range.
  assign w_st_x = {w_st[MEM_W-1], w_st};
  assign w_lk_x = {1'b0, r1_leak};
  assign w_dec  = w_st_x - w_lk_x;
  assign w_inc  = w_st_x + w_lk_x;

  always_comb begin
    w_leaked = w_st;
    if (LEAK_EN != 0) begin
      if (w_st[MEM_W-1])     w_leaked = w_inc[MEM_W] ? w_inc[MEM_W-1:0] : '0;
      else if (w_st != '0)   w_leaked = w_dec[MEM_W] ? '0 : w_dec[MEM_W-1:0];
    end
  end

  assign w_spike   = $signed(w_leaked) >= $signed(r1_thr);
  assign w_sub     = {w_leaked[MEM_W-1], w_leaked} - {r1_thr[MEM_W-1], r1_thr};
  assign w_cnt_inc = (&w_cnt) ? w_cnt : w_cnt + CNT_W'(1);

  always_comb begin
    w_nstate = w_st;
    w_ncnt   = w_cnt;
    w_nspike = 1'b0;
    case (r1_op)
      OP_SYN:  w_nstate = f_sat(w_syn);
      OP_STEP: begin
        if (w_spike) begin
          w_nspike = 1'b1;
          w_ncnt   = w_cnt_inc;
          w_nstate = (RESET_MODE != 0) ? f_sat(w_sub) : '0;
        end else begin
          w_nstate = w_leaked;
        end
      end
      OP_REF: begin
        w_nstate = '0;
        w_ncnt   = '0;
      end
      OP_NOP: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r1_valid  <= 1'b0;
      r1_op     <= '0;
      r1_addr   <= '0;
      r1_state  <= '0;
      r1_cnt    <= '0;
      r1_weight <= '0;
      r1_thr    <= '0;
      r1_leak   <= '0;
      r2_valid  <= 1'b0;
      r2_addr   <= '0;
      r2_state  <= '0;
      r2_cnt    <= '0;
      r2_spike  <= 1'b0;
    end else if (w_adv) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_op     <= in_op;
        r1_addr   <= in_addr;
        r1_state  <= in_state;
        r1_cnt    <= in_cnt;
        r1_weight <= in_weight;
        r1_thr    <= param_thr;
        r1_leak   <= param_leak;
      end
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_addr  <= r1_addr;
        r2_state <= w_nstate;
        r2_cnt   <= w_ncnt;
        r2_spike <= w_nspike;
      end
    end
  end

  assign out_valid = r2_valid;
  assign out_addr  = r2_addr;
  assign out_state = r2_state;
  assign out_cnt   = r2_cnt;
  assign out_spike = r2_spike;

endmodule

// File: tb/tb_lif_neuron_pipe.sv
// Bench for lif_neuron_pipe: two instances (plain, and leak + subtractive reset) share one stimulus stream
// and are checked against an arithmetic reference of the neuron rules.
module tb_lif_neuron_pipe;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid, out_ready;
  logic [1:0]  in_op;
  logic [7:0]  in_addr, in_weight;
  logic [11:0] in_state, param_thr, param_leak;
  logic [6:0]  in_cnt;

  logic        in_ready0, in_ready1, out_valid0, out_valid1, out_spike0, out_spike1;
  logic [7:0]  out_addr0, out_addr1;
  logic [11:0] out_state0, out_state1;
  logic [6:0]  out_cnt0, out_cnt1;

  always #5 CLK = ~CLK;

  lif_neuron_pipe dut0 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready0), .in_op(in_op),
    .in_addr(in_addr), .in_state(in_state), .in_cnt(in_cnt), .in_weight(in_weight),
    .param_thr(param_thr), .param_leak(param_leak), .out_valid(out_valid0), .out_ready(out_ready),
    .out_addr(out_addr0), .out_state(out_state0), .out_cnt(out_cnt0), .out_spike(out_spike0));

  lif_neuron_pipe #(.LEAK_EN(1), .RESET_MODE(1)) dut1 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready1), .in_op(in_op),
    .in_addr(in_addr), .in_state(in_state), .in_cnt(in_cnt), .in_weight(in_weight),
    .param_thr(param_thr), .param_leak(param_leak), .out_valid(out_valid1), .out_ready(out_ready),
    .out_addr(out_addr1), .out_state(out_state1), .out_cnt(out_cnt1), .out_spike(out_spike1));

  typedef struct { int addr; int s; int c; int p; int acc; } res_t;
  typedef struct { int s; int c; int p; int lat; } obs_t;

  res_t exp_q[2][$];
  obs_t hist[2][$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_acc = -10;
  int   last_addr = -1;
  int   last_s[2], last_c[2];
  bit   stall_prev[2];
  int   snap[2];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  // Reference neuron: op 0 SYN, 1 STEP, 2 REF, 3 NOP; weight scaled by 2 (one-bit alignment shift).
  function automatic void model(input int op, input int st, input int cnt, input int w, input int thr,
                                input int leak, input int leak_en, input int rmode,
                                output int ns, output int nc, output int sp);
    int lk;
    ns = st; nc = cnt; sp = 0;
    case (op)
      0: ns = clamp(st + w * 2);
      1: begin
        lk = st;
        if (leak_en != 0) begin
          if (st > 0)      lk = (st - leak < 0) ? 0 : st - leak;
          else if (st < 0) lk = (st + leak > 0) ? 0 : st + leak;
        end
        if (lk >= thr) begin
          sp = 1;
          ns = (rmode != 0) ? clamp(lk - thr) : 0;
          nc = (cnt >= 127) ? 127 : cnt + 1;
        end else begin
          ns = lk;
        end
      end
      2: begin ns = 0; nc = 0; end
      default: ;
    endcase
  endfunction

  task automatic issue(input int op, input int addr, input int st, input int cnt, input int w,
                       input int thr, input int leak);
    bit acc;
    int guard;
    int src_s, src_c, ns, nc, sp;
    res_t e;
    in_op = 2'(op); in_addr = 8'(addr); in_state = 12'(st); in_cnt = 7'(cnt);
    in_weight = 8'(w); param_thr = 12'(thr); param_leak = 12'(leak);
    in_valid = 1'b1;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 50) begin
      @(negedge CLK);
      acc = in_ready0;
      @(posedge CLK);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    for (int k = 0; k < 2; k++) begin
      // Consecutive same-address operations see the previous result, as if the SRAM were coherent.
      if ((cyc - 1 == last_acc + 1) && (addr == last_addr)) begin
        src_s = last_s[k]; src_c = last_c[k];
      end else begin
        src_s = st; src_c = cnt;
      end
      model(op, src_s, src_c, w, thr, leak, k, k, ns, nc, sp);
      e.addr = addr; e.s = ns; e.c = nc; e.p = sp; e.acc = cyc - 1;
      exp_q[k].push_back(e);
      last_s[k] = ns; last_c[k] = nc;
    end
    last_acc = cyc - 1;
    last_addr = addr;
  endtask

  task automatic observe(input int k, input logic v, input int a, input int s, input int c, input int p);
    res_t e;
    obs_t o;
    int cur;
    cur = (a << 20) | ((s & 12'hfff) << 8) | (c << 1) | p;
    if (stall_prev[k]) chk($sformatf("stall_hold%0d", k), cur, snap[k]);
    if (v && out_ready) begin
      if (exp_q[k].size() == 0) begin
        chk($sformatf("unexpected_out%0d", k), 1, 0);
      end else begin
        e = exp_q[k].pop_front();
        chk($sformatf("addr%0d", k), a, e.addr);
        chk($sformatf("state%0d", k), s, e.s);
        chk($sformatf("cnt%0d", k), c, e.c);
        chk($sformatf("spike%0d", k), p, e.p);
        o.s = s; o.c = c; o.p = p; o.lat = cyc - e.acc;
        hist[k].push_back(o);
      end
    end
    stall_prev[k] = v && !out_ready;
    snap[k] = cur;
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      chk("in_ready0_rule", int'(in_ready0), int'(!out_valid0 || out_ready));
      chk("in_ready1_rule", int'(in_ready1), int'(!out_valid1 || out_ready));
      observe(0, out_valid0, int'(out_addr0), int'($signed(out_state0)), int'(out_cnt0), int'(out_spike0));
      observe(1, out_valid1, int'(out_addr1), int'($signed(out_state1)), int'(out_cnt1), int'(out_spike1));
    end else begin
      stall_prev[0] = 1'b0;
      stall_prev[1] = 1'b0;
    end
  end

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && g < 40) begin
      @(posedge CLK);
      g++;
    end
    #1;
    if (exp_q[0].size() != 0 || exp_q[1].size() != 0) chk("drain_timeout", exp_q[0].size(), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid0"}, int'(out_valid0), 0);
    chk({tag, "_valid1"}, int'(out_valid1), 0);
    chk({tag, "_outs0"}, int'(out_addr0) + int'(out_state0) + int'(out_cnt0) + int'(out_spike0), 0);
    chk({tag, "_outs1"}, int'(out_addr1) + int'(out_state1) + int'(out_cnt1) + int'(out_spike1), 0);
  endtask

  task automatic lit(input string name, input int k, input int back, input int s, input int c, input int p);
    int n;
    n = hist[k].size();
    if (n < back) begin
      chk({name, "_missing"}, n, back);
    end else begin
      chk($sformatf("%s_state%0d", name, k), hist[k][n-back].s, s);
      chk($sformatf("%s_cnt%0d", name, k), hist[k][n-back].c, c);
      chk($sformatf("%s_spike%0d", name, k), hist[k][n-back].p, p);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ns, nc, sp, n0, n1;
    in_valid = 1'b0; out_ready = 1'b1; in_op = 2'b11; in_addr = '0; in_state = '0;
    in_cnt = '0; in_weight = '0; param_thr = '0; param_leak = '0;

    model(0, 2040, 0, 10, 512, 50, 0, 0, ns, nc, sp);   chk("pin_syn_pos", ns, 2047);
    model(0, -2040, 0, -10, 512, 50, 0, 0, ns, nc, sp); chk("pin_syn_neg", ns, -2048);
    model(1, 600, 5, 0, 512, 50, 0, 0, ns, nc, sp);     chk("pin_step_rm0", ns * 1000 + nc * 10 + sp, 61);
    model(1, 700, 0, 0, 512, 50, 1, 1, ns, nc, sp);     chk("pin_step_rm1", ns, 138);
    model(1, -30, 0, 0, 512, 50, 1, 1, ns, nc, sp);     chk("pin_leak_neg", ns, 0);
    model(1, 600, 127, 0, 512, 50, 1, 1, ns, nc, sp);   chk("pin_cnt_sat", nc * 10 + sp, 1271);

    repeat (2) @(posedge CLK);
    #1;
    check_zero("reset");
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK);
    #1;

    // SYN saturation both directions
    issue(0, 1, 2040, 3, 10, 512, 50);
    issue(0, 2, -2040, 4, -10, 512, 50);
    drain();
    for (int k = 0; k < 2; k++) begin
      lit("syn_pos", k, 2, 2047, 3, 0);
      lit("syn_neg", k, 1, -2048, 4, 0);
    end

    // STEP with spike, and latency of exactly two cycles
    issue(1, 5, 600, 5, 0, 512, 50);
    drain();
    lit("step600", 0, 1, 0, 6, 1);
    lit("step600", 1, 1, 38, 6, 1);
    chk("latency0", hist[0][hist[0].size()-1].lat, 2);
    issue(1, 6, 511, 5, 0, 512, 50);
    drain();
    lit("step511", 0, 1, 511, 5, 0);
    lit("step511", 1, 1, 461, 5, 0);

    // Leak, subtractive reset, counter saturation
    issue(1, 7, 700, 0, 0, 512, 50);
    issue(1, 8, -30, 0, 0, 512, 50);
    issue(1, 9, 600, 127, 0, 512, 50);
    drain();
    lit("step700", 1, 3, 138, 1, 1);
    lit("leakneg", 1, 2, 0, 0, 0);
    lit("cntsat", 1, 1, 38, 127, 1);
    lit("step700", 0, 3, 0, 1, 1);
    lit("leakneg", 0, 2, -30, 0, 0);
    lit("cntsat", 0, 1, 0, 127, 1);

    // Forwarding on back-to-back same address, none across different addresses
    issue(0, 3, 100, 0, 8, 512, 50);
    issue(0, 3, 100, 0, 8, 512, 50);
    drain();
    lit("fwd_a", 0, 2, 116, 0, 0);
    lit("fwd_b", 0, 1, 132, 0, 0);
    lit("fwd_b", 1, 1, 132, 0, 0);
    issue(0, 10, 100, 0, 8, 512, 50);
    issue(0, 11, 100, 0, 8, 512, 50);
    drain();
    lit("nofwd", 0, 1, 116, 0, 0);
    issue(0, 4, 500, 2, 20, 512, 50);
    issue(1, 4, 500, 2, 0, 512, 50);
    drain();
    lit("fwd_step", 0, 1, 0, 3, 1);
    lit("fwd_step", 1, 1, 490, 2, 0);

    // Backpressure with a three-cycle output stall
    n0 = hist[0].size();
    n1 = hist[1].size();
    fork
      begin
        issue(0, 20, 10, 0, 1, 512, 50);
        issue(0, 21, 20, 0, 2, 512, 50);
        issue(1, 22, 600, 1, 0, 512, 50);
        issue(3, 23, 77, 8, 0, 512, 50);
      end
      begin
        @(posedge CLK);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count0", hist[0].size() - n0, 4);
    chk("bp_count1", hist[1].size() - n1, 4);
    lit("nop", 0, 1, 77, 8, 0);

    // REF clears state and count
    issue(2, 12, -300, 9, 0, 512, 50);
    drain();
    lit("ref", 0, 1, 0, 0, 0);
    lit("ref", 1, 1, 0, 0, 0);

    // Reset with two operations in flight
    issue(0, 30, 5, 0, 1, 512, 50);
    issue(0, 31, 6, 0, 1, 512, 50);
    chk("inflight_visible", int'(out_valid0), 1);
    RST = 1'b1;
    exp_q[0].delete();
    exp_q[1].delete();
    last_acc = -10;
    #1;
    check_zero("midrst");
    @(posedge CLK);
    #1;
    check_zero("midrst_hold");
    @(negedge CLK) RST = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    check_zero("postrst");
    chk("queue_empty", exp_q[0].size() + exp_q[1].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lif_neuron_pipe.md
Name: lif_neuron_pipe

Overview:
- Parametrised, pipelined, time-multiplexed neuron update engine; next generation of the combinational IF neuron.
- Takes a stream of neuron operations (synaptic event, time-step, time-reference) with state and spike count read from neuron SRAM. Returns the updated state/count for write-back.
- Adds optional leak, selectable reset-to-zero or reset-by-subtraction, saturating spike counter, valid/ready backpressure, and read-after-write forwarding for back-to-back operations on the same neuron.
- Sits between the neuron SRAM read port and write port in the core controller.

Parameters:
- MEM_W, 12: membrane state width, signed two's complement.
- WGT_W, 8: synaptic weight width, signed.
- WGT_SHIFT, 1: left shift aligning weight fraction to membrane fraction (S2.5 -> S5.6).
- CNT_W, 7: post-spike counter width, unsigned.
- ADDR_W, 8: neuron address width.
- LEAK_EN, 0: 1 enables leak on time-step.
- RESET_MODE, 0: 0 = reset to zero on spike; 1 = subtract threshold on spike.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous, active-high reset
- in_valid  in  1  operation valid
- in_ready  out  1  engine accepts operation
- in_op  in  2  00 SYN, 01 STEP, 10 REF, 11 NOP
- in_addr  in  ADDR_W  neuron address
- in_state  in  MEM_W  membrane state from SRAM (signed)
- in_cnt  in  CNT_W  post-spike count from SRAM
- in_weight  in  WGT_W  synaptic weight (signed; used by SYN only)
- param_thr  in  MEM_W  firing threshold (signed), sampled with operation
- param_leak  in  MEM_W  leak magnitude (unsigned, 0..max), sampled with operation
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_addr  out  ADDR_W  neuron address of result
- out_state  out  MEM_W  next membrane state (signed)
- out_cnt  out  CNT_W  next post-spike count
- out_spike  out  1  spike fired (STEP only)

Behaviour:
- Reset (asynchronous, active-high):
  - All valid flags clear; out_addr, out_state, out_cnt and out_spike are 0.
  - Any in-flight operation is discarded, including one reset mid-pipeline.
- Pipeline: two stages.
  - S1 registers the operation and parameters.
  - S2 (output register) holds the computed result.
  - Latency: accept in cycle N gives out_valid in cycle N+2 absent stalls.
  - Throughput: 1 operation/cycle.
- Handshake:
  - Global stall: adv = !out_valid | out_ready; in_ready = adv.
  - Transfer occurs on in_valid & in_ready.
  - When adv=0, S1 and S2 hold all contents; out_* stay stable while out_valid=1 and out_ready=0.
- Forwarding:
  - When S1 advances into S2 and S2 holds a valid result with out_addr == S1 address, S2 computes from the S2 out_state/out_cnt instead of the S1 SRAM values.
  - This covers the SRAM write-back hazard. With no match, use the S1 values.
- SYN:
  - w_ext = sign-extend(in_weight) << WGT_SHIFT, to MEM_W.
  - sum = state + w_ext with signed saturation to [-2^(MEM_W-1), 2^(MEM_W-1)-1].
  - cnt unchanged; spike 0.
- STEP:
  - If LEAK_EN, the leaked value moves state toward 0 by param_leak, clamping at 0 if it would cross:
    - state > 0: state' = max(state - leak, 0).
    - state < 0: state' = min(state + leak, 0).
    - state = 0: unchanged.
  - If LEAK_EN=0, the leaked value equals state.
  - spike = (leaked >= param_thr), signed compare.
  - On spike, the new state depends on RESET_MODE:
    - RESET_MODE 0: state = 0.
    - RESET_MODE 1: state = leaked - param_thr, saturating.
  - Without spike, state = leaked.
  - On spike, cnt + 1, saturating at 2^CNT_W-1 with no wrap; spike still reported.
- REF: state = 0, cnt = 0, spike = 0.
- NOP: state and cnt pass through (after forwarding); spike = 0.
- Parameters param_thr and param_leak are captured in S1; changes after acceptance do not affect that operation.

Test Plan:
- SYN saturation: state=2040, weight=+10 (w_ext=20) -> out_state=2047, spike=0. state=-2040, weight=-10 -> out_state=-2048.
- STEP spike, RESET_MODE 0: state=600, thr=512 -> spike=1, out_state=0, cnt 5 -> 6, out_valid exactly 2 cycles after accept. Variant state=511 -> spike=0, state 511, cnt 5.
- RESET_MODE 1 and leak (LEAK_EN=1):
  - state=700, leak=50, thr=512 -> spike=1, out_state=138.
  - state=-30, leak=50 -> out_state=0.
  - cnt=127 with spike -> cnt stays 127, spike=1.
- Forwarding: back-to-back SYN addr 3 (state 100, weight +8), then SYN addr 3 with stale in_state=100, weight +8 -> results 116 then 132. Same sequence with different addresses -> no forwarding.
- Backpressure: stream 4 operations, hold out_ready=0 for 3 cycles -> in_ready=0 while the output is full, out_* stable, no loss/duplication, order preserved.
- REF and reset: REF on state=-300, cnt=9 -> 0/0. Assert RST with 2 operations in flight -> out_valid=0 next cycle, all outputs 0, no result emitted after release.
